// File: rtl/sysbus_pkg.sv
// Sysbus shared definitions: responder state encoding and tag field layout.
// The same package is used by memory_controller on the initiator side.
package sysbus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DATA  = 2'd1,
    RD_WAIT  = 2'd2,
    RD_BURST = 2'd3
  } state_t;

  localparam int          BEATS         = 8;
  localparam int          TAG_WRITE_BIT = 12;
  localparam int          TAG_TYPE_LSB  = 8;
  localparam int          TAG_TYPE_W    = 4;
  localparam logic [3:0]  TYPE_MEMORY   = 4'h1;

endpackage

// File: rtl/sysbus_mem_array.sv
// Backing word store: one synchronous write port, one combinational read port.
// Contents are never reset.
module sysbus_mem_array #(
  parameter int DW = 64,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: 8-beat block writes into a word array, and
// critical-word-first 8-beat read bursts returned after a fixed latency.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respack,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = AW - 3;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t                     r_state;
  logic [BW-1:0]              r_base;
  logic [2:0]                 r_start;
  logic [2:0]                 r_beat;
  logic [LW-1:0]              r_lat;
  logic [BUS_TAG_WIDTH-1:0]   r_tag;

  logic                       w_accept;
  logic                       w_we;
  logic [2:0]                 w_rbeat;
  logic [AW-1:0]              w_waddr;
  logic [AW-1:0]              w_raddr;
  logic [BUS_DATA_WIDTH-1:0]  w_rdata;
  logic                       w_last;

  // A held beat is only taken on a cycle where the previous one was not acked.
  assign w_accept = bus_reqcyc && !bus_reqack &&
                    ((r_state == IDLE) || (r_state == WR_DATA));
  assign w_we     = w_accept && (r_state == WR_DATA);
  assign w_waddr  = {r_base, r_beat};
  // RD_WAIT fetches the critical word; RD_BURST prefetches the next one.
  assign w_rbeat  = (r_state == RD_WAIT) ? r_start : (r_start + r_beat + 3'd1);
  assign w_raddr  = {r_base, w_rbeat};
  assign w_last   = (r_beat == 3'(BEATS - 1));

  sysbus_mem_array #(
    .DW (BUS_DATA_WIDTH),
    .AW (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (bus_req),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_start     <= '0;
      r_beat      <= '0;
      r_lat       <= '0;
      r_tag       <= '0;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
    end else begin
      bus_reqack <= w_accept;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_base  <= bus_req[6 +: BW];
            r_start <= bus_req[5:3];
            r_tag   <= bus_reqtag;
            r_beat  <= '0;
            r_lat   <= '0;
            if (bus_reqtag[TAG_WRITE_BIT])
              r_state <= WR_DATA;
            else if (bus_reqtag[TAG_TYPE_LSB +: TAG_TYPE_W] == TYPE_MEMORY)
              r_state <= RD_WAIT;
          end
        end
        WR_DATA: begin
          if (w_accept) begin
            r_beat <= r_beat + 3'd1;
            if (w_last) r_state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (r_lat == LW'(READ_LATENCY - 1)) begin
            bus_resp    <= w_rdata;
            bus_respcyc <= 1'b1;
            bus_resptag <= r_tag;
            r_beat      <= '0;
            r_state     <= RD_BURST;
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end
        RD_BURST: begin
          if (bus_respcyc && bus_respack) begin
            if (w_last) begin
              bus_respcyc <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_beat   <= r_beat + 3'd1;
              bus_resp <= w_rdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: block write, latency-exact reads,
// wrap order, backpressure hold, request hold-off during bursts, mid-burst reset.
module tb_sysbus_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respack;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  int n_vec = 0;
  int n_err = 0;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .MEM_WORDS      (4096),
    .READ_LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_respack (bus_respack),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request beat: accepted at the next edge, ack seen, then ack drops.
  task automatic req_beat(input logic [63:0] d, input logic [12:0] t);
    bus_reqcyc = 1'b1; bus_req = d; bus_reqtag = t;
    @(negedge clk);
    chk("reqack_pulse", bus_reqack, 1);
    bus_reqcyc = 1'b0;
    @(negedge clk);
    chk("reqack_drop", bus_reqack, 0);
  endtask

  // Issue a read and verify the first beat appears exactly LAT cycles after acceptance.
  task automatic rd_issue(input logic [63:0] a, input logic [12:0] t);
    bus_reqcyc = 1'b1; bus_req = a; bus_reqtag = t;
    @(negedge clk);
    chk("rd_reqack", bus_reqack, 1);
    bus_reqcyc = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      chk("rd_wait_respcyc", bus_respcyc, 0);
    end
    @(negedge clk);
    chk("rd_first_respcyc", bus_respcyc, 1);
    chk("rd_resptag", bus_resptag, 64'(t));
  endtask

  // Consume beats from..to of a burst whose critical word is at index st.
  task automatic rd_beats(input int from, input int to, input int st, input logic [12:0] t);
    bus_respack = 1'b1;
    for (int k = from; k <= to; k++) begin
      chk("rd_beat_data", bus_resp, 64'(8'hA0 + ((st + k) & 7)));
      chk("rd_beat_tag", bus_resptag, 64'(t));
      @(negedge clk);
    end
    bus_respack = 1'b0;
    if (to == 7) chk("rd_end_respcyc", bus_respcyc, 0);
  endtask

  initial begin
    reset = 1'b1; bus_reqcyc = 1'b1; bus_req = 64'h1000;
    bus_reqtag = 13'h0100; bus_respack = 1'b0;

    // 1: reset held 3 cycles with a request pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_reqack", bus_reqack, 0);
      chk("rst_respcyc", bus_respcyc, 0);
      chk("rst_resp", bus_resp, 0);
      chk("rst_resptag", bus_resptag, 0);
    end
    reset = 1'b0; bus_reqcyc = 1'b0;
    @(negedge clk);
    chk("post_rst_reqack", bus_reqack, 0);

    // 2: block write of 0xA0..0xA7 to 0x1000, then read back in order
    req_beat(64'h1000, 13'h1100);
    for (int i = 0; i < 8; i++) req_beat(64'(8'hA0 + i), 13'h1100);
    chk("wr_no_resp", bus_respcyc, 0);
    rd_issue(64'h1000, 13'h0105);
    rd_beats(0, 7, 0, 13'h0105);

    // 3: critical-word-first from word 3
    rd_issue(64'h1018, 13'h0107);
    rd_beats(0, 7, 3, 13'h0107);

    // address aliasing above MEM_WORDS*8
    rd_issue(64'h9000, 13'h010A);
    rd_beats(0, 7, 0, 13'h010A);

    // 4: backpressure on beat 2 for 5 cycles
    rd_issue(64'h1000, 13'h0109);
    rd_beats(0, 1, 0, 13'h0109);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_resp", bus_resp, 64'hA2);
      chk("hold_tag", bus_resptag, 64'h0109);
      chk("hold_respcyc", bus_respcyc, 1);
    end
    rd_beats(2, 7, 0, 13'h0109);

    // 5: request held through a burst is only taken once back in IDLE
    rd_issue(64'h1000, 13'h010B);
    bus_reqcyc = 1'b1; bus_req = 64'h2000; bus_reqtag = 13'h0200;
    bus_respack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("holdoff_data", bus_resp, 64'(8'hA0 + k));
      chk("holdoff_reqack", bus_reqack, 0);
      @(negedge clk);
    end
    bus_respack = 1'b0;
    chk("holdoff_end_respcyc", bus_respcyc, 0);
    chk("holdoff_end_reqack", bus_reqack, 0);
    @(negedge clk);
    chk("holdoff_accept", bus_reqack, 1);
    bus_reqcyc = 1'b0;
    @(negedge clk);
    chk("holdoff_ack_drop", bus_reqack, 0);
    chk("nonmem_no_resp", bus_respcyc, 0);

    // 6: reset while beat 4 is presented, then data still intact
    rd_issue(64'h1000, 13'h010C);
    rd_beats(0, 3, 0, 13'h010C);
    chk("pre_rst_beat4", bus_resp, 64'hA4);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_respcyc", bus_respcyc, 0);
    chk("midrst_resp", bus_resp, 0);
    chk("midrst_resptag", bus_resptag, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_idle", bus_respcyc, 0);
    rd_issue(64'h1000, 13'h010D);
    rd_beats(0, 7, 0, 13'h010D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
